branch_hazard_ctrl: RTL and testbench
=====================================

# branch_hazard_ctrl

Pipeline control block that consumes the ID-stage branch decision (the 1-bit taken result from the branch comparator) and drives the fetch/decode side of the 5-stage MIPS pipeline. It sits between the ID stage and the PC/IF-ID/ID-EX registers. It does three things:
- detects data hazards on branch operands and load-use hazards, and inserts the required stalls;
- registers taken-branch targets and redirects the PC one cycle later;
- squashes wrong-path instructions.

## Interface
Parameters:
- none

Ports:
- Clk  in  1  pipeline clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- IsBranch  in  1  ID instruction is a conditional branch
- BranchTaken  in  1  comparator result for the ID branch
- BranchTarget  in  32  computed target for the ID branch
- ID_Rs, ID_Rt  in  5  ID source registers
- UsesRt  in  1  ID instruction reads Rt (beq/bne, R-type, stores)
- EX_RegWrite, EX_MemRead  in  1  EX stage write-back and load flags
- EX_Rd  in  5  EX destination register
- MEM_MemRead  in  1  MEM stage load flag
- MEM_Rd  in  5  MEM destination register
- PCWrite  out  1  PC load enable
- IFIDWrite  out  1  IF/ID load enable
- IFIDFlush  out  1  replace IF/ID contents with nop
- IDEXBubble  out  1  zero the ID/EX control fields
- PCSrc  out  1  select PCTarget over PC+4
- PCTarget  out  32  registered redirect address

## Operation
Register-match rule:
- A "match" means the destination equals ID_Rs, or equals ID_Rt with UsesRt=1.
- Destination register 0 never matches.

Stall need N, the maximum of:
- IsBranch & EX_MemRead & EX match → 2
- IsBranch & EX_RegWrite & !EX_MemRead & EX match → 1
- IsBranch & MEM_MemRead & MEM match → 1
- !IsBranch & EX_MemRead & EX match → 1

States: RUN, STALL, REDIRECT.
- **RUN, N>0:**
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  - BranchTaken is ignored.
  - N=2 → STALL with cnt=1. N=1 → stay RUN and re-evaluate next cycle.
- **RUN, N=0, IsBranch & BranchTaken:**
  - PCTarget ← BranchTarget.
  - Next state REDIRECT.
  - The pipeline advances normally this cycle.
- **RUN, otherwise:** PCWrite=1, IFIDWrite=1, no flush, no bubble.
- **STALL:**
  - Same stall outputs as RUN with N>0.
  - cnt decrements each cycle; when cnt reaches 0, next state is RUN.
  - Inputs are not re-evaluated in this state.
- **REDIRECT:**
  - PCSrc=1, PCWrite=1, IFIDFlush=1, IDEXBubble=1 (see Configuration).
  - ID inputs are ignored.
  - Next state is RUN unconditionally.
- A branch that completes its stalls is evaluated on the first RUN cycle after them.

## Timing
- Reset (Reset_n=0, asynchronous):
  - State returns to RUN, cnt=0, PCTarget=0.
  - Outputs: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0, PCSrc=0.
- Stall outputs are Mealy: they are asserted in the same cycle the hazard is visible.
- Redirect latency is 1 cycle.
  - Branch decided at edge t; PCSrc=1 during cycle t+1; PC=target after edge t+1.
- Taken-branch penalty: 2 cycles without delay slot, 1 cycle with it.
- Not-taken penalty: 0.
- Reset asserted in STALL or REDIRECT aborts the operation. A pending redirect is dropped.
- Back-to-back branches: the branch in ID during REDIRECT is wrong-path and is never evaluated.

## Configuration
- DELAY_SLOT_EN defined:
  - In REDIRECT, IDEXBubble=0, so the delay-slot instruction proceeds. Only the IF/ID fetch is flushed.
  - The delay-slot instruction is not hazard-checked. Software guarantees it has no load-use dependency and is not a branch.
- DELAY_SLOT_EN undefined: REDIRECT bubbles ID and flushes IF/ID.

## Test plan
- **lw $t0 then beq $t0,$t1 back-to-back:** EX_MemRead=1, EX_Rd=8, ID_Rs=8, IsBranch=1 → PCWrite=0 for exactly 2 cycles, IDEXBubble=1 for both, then branch evaluated.
- **add $t0 then bne $t0,$zero:** EX_RegWrite=1, EX_Rd=8 → 1 stall cycle. Same pattern with EX_Rd=0 → 0 stalls.
- **beq taken, no hazard, BranchTarget=0x0040_0100:**
  - Next cycle: PCSrc=1, PCTarget=0x0040_0100, IFIDFlush=1.
  - IDEXBubble=1 without DELAY_SLOT_EN, 0 with it.
- **beq not taken:** PCSrc stays 0, no flush, no stall.
- **Non-branch load-use:** lw $t2 then add using $t2 as Rt with UsesRt=1 → 1 stall. UsesRt=0 → no stall.
- **Reset_n pulsed low mid-STALL:** outputs immediately take reset values, and the next cycle is RUN with PCTarget=0.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// branch_hazard_ctrl
//
// Fetch/decode control for a 5-stage MIPS pipeline with branches resolved in
// ID. It detects branch-operand and load-use data hazards and stalls PC and
// IF/ID while it bubbles ID/EX. It registers taken-branch targets and redirects
// the PC one cycle later. It also squashes wrong-path fetches.
//
// Optional feature macro: DELAY_SLOT_EN
//   defined   - during a redirect only the IF/ID fetch is flushed. The
//               delay-slot instruction in ID proceeds into EX.
//   undefined - during a redirect IF/ID is flushed and ID/EX is bubbled.
//
// Ports:
//   Clk           pipeline clock, rising edge
//   Reset_n       asynchronous active-low reset
//   IsBranch      ID instruction is a conditional branch
//   BranchTaken   comparator result for the ID branch
//   BranchTarget  computed target of the ID branch (32 bits)
//   ID_Rs, ID_Rt  ID source registers
//   UsesRt        ID instruction reads Rt
//   EX_RegWrite   EX stage writes a register
//   EX_MemRead    EX stage is a load
//   EX_Rd         EX destination register
//   MEM_MemRead   MEM stage is a load
//   MEM_Rd        MEM destination register
//   PCWrite       PC load enable
//   IFIDWrite     IF/ID load enable
//   IFIDFlush     replace IF/ID contents with a nop
//   IDEXBubble    zero the ID/EX control fields
//   PCSrc         select PCTarget over PC+4
//   PCTarget      registered redirect address
// -----------------------------------------------------------------------------
module branch_hazard_ctrl (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        IsBranch,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        UsesRt,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rd,
    input  logic        MEM_MemRead,
    input  logic [4:0]  MEM_Rd,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        PCSrc,
    output logic [31:0] PCTarget
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t      state_r;
    logic [1:0]  cnt_r;
    logic [31:0] target_r;

    logic        ex_match_s;
    logic        mem_match_s;
    logic        need2_s;
    logic        need1_s;
    logic [1:0]  stall_need_s;

    // A producer matches when it writes Rs, or Rt that the ID instruction
    // actually reads. $zero is never a real producer.
    function automatic logic reg_match(input logic [4:0] rd,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        logic m;
        if (rd == 5'd0) begin
            m = 1'b0;
        end else begin
            m = (rd == rs) || (uses_rt && (rd == rt));
        end
        return m;
    endfunction

    // Stall need N. It is forced to 0 while reset is held so that the Mealy
    // outputs show their reset values immediately.
    always_comb begin
        ex_match_s   = reg_match(EX_Rd, ID_Rs, ID_Rt, UsesRt);
        mem_match_s  = reg_match(MEM_Rd, ID_Rs, ID_Rt, UsesRt);
        need2_s      = IsBranch && EX_MemRead && ex_match_s;
        need1_s      = (IsBranch && EX_RegWrite && !EX_MemRead && ex_match_s) ||
                       (IsBranch && MEM_MemRead && mem_match_s) ||
                       (!IsBranch && EX_MemRead && ex_match_s);
        stall_need_s = 2'd0;
        if (!Reset_n) begin
            stall_need_s = 2'd0;
        end else if (need2_s) begin
            stall_need_s = 2'd2;
        end else if (need1_s) begin
            stall_need_s = 2'd1;
        end else begin
            stall_need_s = 2'd0;
        end
    end

    // Control FSM: state, remaining stall count and latched redirect target.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r  <= ST_RUN;
            cnt_r    <= 2'd0;
            target_r <= 32'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (stall_need_s == 2'd2) begin
                        // The first stall cycle is this one, and STALL covers the second.
                        state_r <= ST_STALL;
                        cnt_r   <= 2'd1;
                    end else if (stall_need_s == 2'd1) begin
                        // Stay here and re-check once the producer has moved on.
                        state_r <= ST_RUN;
                    end else if (IsBranch && BranchTaken) begin
                        target_r <= BranchTarget;
                        state_r  <= ST_REDIRECT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_STALL: begin
                    cnt_r <= cnt_r - 2'd1;
                    if (cnt_r <= 2'd1) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_STALL;
                    end
                end
                ST_REDIRECT: begin
                    // The instruction in ID is wrong-path and is never evaluated.
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r <= ST_RUN;
                    cnt_r   <= 2'd0;
                end
            endcase
        end
    end

    // Pipeline control outputs. Stall outputs follow the current hazard
    // (Mealy), and redirect outputs follow the state.
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        PCSrc      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (stall_need_s != 2'd0) begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXBubble = 1'b1;
                end else begin
                    PCWrite    = 1'b1;
                    IFIDWrite  = 1'b1;
                end
            end
            ST_STALL: begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXBubble = 1'b1;
            end
            ST_REDIRECT: begin
                PCSrc      = 1'b1;
                PCWrite    = 1'b1;
                IFIDFlush  = 1'b1;
`ifdef DELAY_SLOT_EN
                IDEXBubble = 1'b0;
`else
                IDEXBubble = 1'b1;
`endif
            end
            default: begin
                PCWrite    = 1'b1;
                IFIDWrite  = 1'b1;
            end
        endcase
    end

    assign PCTarget = target_r;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_hazard_ctrl
//
// Directed self-checking bench for branch_hazard_ctrl. Inputs are driven 1 ns
// after a rising edge. Outputs are sampled 1 ns later, which is well before
// the next edge. Control outputs are compared as one packed vector
// {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PCSrc}.
// -----------------------------------------------------------------------------
module tb_branch_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        IsBranch;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        UsesRt;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic [4:0]  EX_Rd;
    logic        MEM_MemRead;
    logic [4:0]  MEM_Rd;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        IDEXBubble;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic [4:0]  outs;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00010;
`ifdef DELAY_SLOT_EN
    localparam logic [4:0] O_REDIR = 5'b11101;
`else
    localparam logic [4:0] O_REDIR = 5'b11111;
`endif

    branch_hazard_ctrl dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .IsBranch     (IsBranch),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .UsesRt       (UsesRt),
        .EX_RegWrite  (EX_RegWrite),
        .EX_MemRead   (EX_MemRead),
        .EX_Rd        (EX_Rd),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_Rd       (MEM_Rd),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .IFIDFlush    (IFIDFlush),
        .IDEXBubble   (IDEXBubble),
        .PCSrc        (PCSrc),
        .PCTarget     (PCTarget)
    );

    assign outs = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PCSrc};

    always #5 Clk = ~Clk;

    task automatic idle();
        IsBranch     = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = 32'd0;
        ID_Rs        = 5'd0;
        ID_Rt        = 5'd0;
        UsesRt       = 1'b0;
        EX_RegWrite  = 1'b0;
        EX_MemRead   = 1'b0;
        EX_Rd        = 5'd0;
        MEM_MemRead  = 1'b0;
        MEM_Rd       = 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        idle();
        // Hazard inputs are present during reset, and the outputs must still show reset values.
        IsBranch = 1'b1; EX_MemRead = 1'b1; EX_Rd = 5'd8; ID_Rs = 5'd8;
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs, O_RUN); end
        checks++;
        if (PCTarget !== 32'd0) begin errors++; $display("FAIL reset_target: got %h expected %h", PCTarget, 32'd0); end
        next_cycle();
        Reset_n = 1'b1;
        idle();
        next_cycle();
    endtask

    // lw $t0 ; beq $t0,$t1 with two stalls, then the branch is evaluated (taken).
    task automatic test_load_branch();
        idle();
        IsBranch = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'hDEAD_BEEC;
        ID_Rs = 5'd8; ID_Rt = 5'd9; UsesRt = 1'b1;
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd8;
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL lb_stall1: got %b expected %b", outs, O_STALL); end
        next_cycle();
        // The load is now in MEM. STALL does not re-evaluate this.
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_Rd = 5'd0;
        MEM_MemRead = 1'b1; MEM_Rd = 5'd8;
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL lb_stall2: got %b expected %b", outs, O_STALL); end
        next_cycle();
        MEM_MemRead = 1'b0; MEM_Rd = 5'd0; BranchTarget = 32'h0040_0200;
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL lb_eval: got %b expected %b", outs, O_RUN); end
        next_cycle();
        idle();
        #1;
        checks++;
        if (outs !== O_REDIR) begin errors++; $display("FAIL lb_redir: got %b expected %b", outs, O_REDIR); end
        checks++;
        if (PCTarget !== 32'h0040_0200) begin errors++; $display("FAIL lb_target: got %h expected %h", PCTarget, 32'h0040_0200); end
        next_cycle();
    endtask

    // add $t0 ; bne $t0,$zero gives one stall. With EX_Rd=0 there is no stall. A MEM load into Rt gives one stall.
    task automatic test_alu_branch();
        idle();
        IsBranch = 1'b1; ID_Rs = 5'd8; ID_Rt = 5'd0; UsesRt = 1'b1;
        EX_RegWrite = 1'b1; EX_Rd = 5'd8;
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL alu_stall: got %b expected %b", outs, O_STALL); end
        next_cycle();
        EX_RegWrite = 1'b0; EX_Rd = 5'd0;
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL alu_after: got %b expected %b", outs, O_RUN); end
        next_cycle();
        EX_RegWrite = 1'b1; EX_Rd = 5'd0;
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL alu_zero_rd: got %b expected %b", outs, O_RUN); end
        next_cycle();
        idle();
        IsBranch = 1'b1; ID_Rs = 5'd4; ID_Rt = 5'd9; UsesRt = 1'b1;
        MEM_MemRead = 1'b1; MEM_Rd = 5'd9;
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL mem_load_stall: got %b expected %b", outs, O_STALL); end
        next_cycle();
        MEM_MemRead = 1'b0; MEM_Rd = 5'd0;
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL mem_load_after: got %b expected %b", outs, O_RUN); end
        next_cycle();
    endtask

    // Taken branch with no hazard. The next branch (in REDIRECT) is wrong-path and must be ignored.
    task automatic test_back_to_back();
        idle();
        IsBranch = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h0040_0100;
        ID_Rs = 5'd2; ID_Rt = 5'd3; UsesRt = 1'b1;
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL tk_decide: got %b expected %b", outs, O_RUN); end
        next_cycle();
        BranchTarget = 32'h1111_1110; EX_MemRead = 1'b1; EX_Rd = 5'd2;
        #1;
        checks++;
        if (outs !== O_REDIR) begin errors++; $display("FAIL tk_redir: got %b expected %b", outs, O_REDIR); end
        checks++;
        if (PCTarget !== 32'h0040_0100) begin errors++; $display("FAIL tk_target: got %h expected %h", PCTarget, 32'h0040_0100); end
        next_cycle();
        idle();
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL tk_after: got %b expected %b", outs, O_RUN); end
        checks++;
        if (PCTarget !== 32'h0040_0100) begin errors++; $display("FAIL tk_wrongpath_target: got %h expected %h", PCTarget, 32'h0040_0100); end
        next_cycle();
    endtask

    task automatic test_not_taken();
        idle();
        IsBranch = 1'b1; BranchTaken = 1'b0; BranchTarget = 32'h0040_0300;
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL nt_decide: got %b expected %b", outs, O_RUN); end
        next_cycle();
        idle();
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL nt_next: got %b expected %b", outs, O_RUN); end
        next_cycle();
    endtask

    // lw $t2 ; add ..,$t2 (Rt) stalls once when Rt is used and does not stall otherwise.
    task automatic test_load_use();
        idle();
        ID_Rs = 5'd3; ID_Rt = 5'd10; UsesRt = 1'b1;
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd10;
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL lu_stall: got %b expected %b", outs, O_STALL); end
        next_cycle();
        UsesRt = 1'b0;
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL lu_no_rt: got %b expected %b", outs, O_RUN); end
        next_cycle();
        // A non-load ALU producer never stalls a non-branch instruction.
        UsesRt = 1'b1; EX_MemRead = 1'b0;
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL lu_alu_fwd: got %b expected %b", outs, O_RUN); end
        next_cycle();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        IsBranch = 1'b1; ID_Rs = 5'd8; EX_MemRead = 1'b1; EX_Rd = 5'd8;
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL rs_stall1: got %b expected %b", outs, O_STALL); end
        next_cycle();
        idle();
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL rs_in_stall: got %b expected %b", outs, O_STALL); end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL rs_async: got %b expected %b", outs, O_RUN); end
        checks++;
        if (PCTarget !== 32'd0) begin errors++; $display("FAIL rs_target: got %h expected %h", PCTarget, 32'd0); end
        next_cycle();
        Reset_n = 1'b1;
        next_cycle();
        // Idle inputs: STALL would hold the stall outputs, so O_RUN shows that the state is RUN.
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL rs_after: got %b expected %b", outs, O_RUN); end
    endtask

    task automatic test_reset_redirect();
        idle();
        IsBranch = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h0040_0500;
        next_cycle();
        idle();
        Reset_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_RUN) begin errors++; $display("FAIL rr_dropped: got %b expected %b", outs, O_RUN); end
        checks++;
        if (PCTarget !== 32'd0) begin errors++; $display("FAIL rr_target: got %h expected %h", PCTarget, 32'd0); end
        next_cycle();
        Reset_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        Reset_n = 1'b0;
        idle();
        next_cycle();
        test_reset();
        test_load_branch();
        test_alu_branch();
        test_back_to_back();
        test_not_taken();
        test_load_use();
        test_reset_mid_stall();
        test_reset_redirect();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
